// File: rtl/muacm_tx_packer.sv
// muacm_tx_packer: transmit-side packetiser for the muacm IN pipe.
// Buffers a user byte stream in a FIFO with a registered show-ahead head
// stage and closes USB packets at PKT_MAX bytes, on usr_flush, or (when the
// MUACM_TX_TIMEOUT_EN macro is defined) after TIMEOUT idle cycles.
module muacm_tx_packer #(
  parameter int DEPTH   = 64,
  parameter int PKT_MAX = 64,
  parameter int TIMEOUT = 1023
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [7:0]               usr_data,
  input  logic                     usr_valid,
  output logic                     usr_ready,
  input  logic                     usr_flush,
  output logic [7:0]               in_data,
  output logic                     in_last,
  output logic                     in_valid,
  input  logic                     in_ready,
  output logic                     in_flush_now,
  output logic                     in_flush_time,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int PW = $clog2(PKT_MAX) + 1;

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_FLUSH} state_t;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [LW-1:0] mcnt_q, mcnt_d;
  logic [LW-1:0] level_q, level_d;
  logic [LW-1:0] fcnt_q, fcnt_d;
  logic [PW-1:0] pcnt_q, pcnt_d;
  logic [7:0]    head_q;
  logic          hv_q, hv_d;
  logic          fnow_q, fnow_d;
  state_t        state_q, state_d;

  logic wr, rd, load, req, tmo;

  // Handshakes; the head register refills whenever it is empty or being read.
  assign wr       = usr_valid & usr_ready;
  assign rd       = hv_q & in_ready;
  assign load     = (mcnt_q != '0) && (!hv_q || rd);
  assign req      = usr_flush | tmo;
  assign level_d  = level_q + LW'(wr) - LW'(rd);
  assign mcnt_d   = mcnt_q + LW'(wr) - LW'(load);
  assign hv_d     = load ? 1'b1 : (rd ? 1'b0 : hv_q);

  assign usr_ready    = (level_q != LW'(DEPTH));
  assign in_valid     = hv_q;
  assign in_data      = head_q;
  assign in_last      = hv_q & ((pcnt_q == PW'(PKT_MAX - 1)) | (fcnt_q == LW'(1)));
  assign in_flush_now = fnow_q;
  assign level        = level_q;

`ifdef MUACM_TX_TIMEOUT_EN
  logic [15:0] idle_q, idle_d;

  // Idle counter: counts write-free cycles while data is pending, fires once at TIMEOUT.
  always_comb begin
    idle_d = idle_q;
    tmo    = 1'b0;
    if (wr) begin
      idle_d = '0;
    end else if (level_q != '0 || pcnt_q != '0) begin
      if (idle_q == 16'(TIMEOUT - 1)) begin
        tmo    = 1'b1;
        idle_d = '0;
      end else begin
        idle_d = idle_q + 16'd1;
      end
    end else begin
      idle_d = '0;
    end
  end

  // Idle counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) idle_q <= '0;
    else        idle_q <= idle_d;
  end

  assign in_flush_time = 1'b0;
`else
  assign tmo           = 1'b0;
  assign in_flush_time = 1'b1;
`endif

  // Packet byte counter: wraps at the byte carrying in_last or after a flush pulse.
  always_comb begin
    pcnt_d = pcnt_q;
    if (rd)          pcnt_d = in_last ? '0 : pcnt_q + PW'(1);
    else if (fnow_q) pcnt_d = '0;
  end

  // Flush FSM and flush byte counter; a new request reloads the remaining count.
  always_comb begin
    state_d = state_q;
    fnow_d  = 1'b0;
    fcnt_d  = fcnt_q;
    if (rd && fcnt_q != '0) fcnt_d = fcnt_q - LW'(1);
    if (req)                fcnt_d = level_d;
    case (state_q)
      S_IDLE, S_STREAM: begin
        if (req && level_d != '0) begin
          state_d = S_FLUSH;
        end else if (req && pcnt_q != '0 && !fnow_q) begin
          fnow_d  = 1'b1;
          state_d = S_IDLE;
        end else if (state_q == S_IDLE && wr) begin
          state_d = S_STREAM;
        end
      end
      S_FLUSH: begin
        if (rd && fcnt_q == LW'(1)) begin
          fnow_d = 1'b1;
          if (!(req && level_d != '0)) state_d = (level_d == '0) ? S_IDLE : S_STREAM;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FIFO storage write port; contents need no reset since pointers gate them.
  always_ff @(posedge clk) begin
    if (wr) mem_q[wptr_q] <= usr_data;
  end

  // State, pointers, counters and the show-ahead head register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      mcnt_q  <= '0;
      level_q <= '0;
      fcnt_q  <= '0;
      pcnt_q  <= '0;
      head_q  <= 8'h00;
      hv_q    <= 1'b0;
      fnow_q  <= 1'b0;
      state_q <= S_IDLE;
    end else begin
      if (wr)   wptr_q <= wptr_q + AW'(1);
      if (load) begin
        rptr_q <= rptr_q + AW'(1);
        head_q <= mem_q[rptr_q];
      end
      mcnt_q  <= mcnt_d;
      level_q <= level_d;
      fcnt_q  <= fcnt_d;
      pcnt_q  <= pcnt_d;
      hv_q    <= hv_d;
      fnow_q  <= fnow_d;
      state_q <= state_d;
    end
  end

endmodule

// File: tb/tb_muacm_tx_packer.sv
// Testbench for muacm_tx_packer: directed scenarios plus a randomized phase,
// all checked against a queue-based packet model of the transmit rules.
module tb_muacm_tx_packer;

   localparam int DEPTH   = 64;
   localparam int PKT_MAX = 64;
   localparam int TMO     = 16;
   localparam int LW      = $clog2(DEPTH) + 1;
`ifdef MUACM_TX_TIMEOUT_EN
   localparam logic EXP_FT = 1'b0;
`else
   localparam logic EXP_FT = 1'b1;
`endif

   logic          clk;
   logic          rst_n;
   logic [7:0]    usr_data;
   logic          usr_valid;
   logic          usr_ready;
   logic          usr_flush;
   logic [7:0]    in_data;
   logic          in_last;
   logic          in_valid;
   logic          in_ready;
   logic          in_flush_now;
   logic          in_flush_time;
   logic [LW-1:0] level;

   muacm_tx_packer #(.DEPTH(DEPTH), .PKT_MAX(PKT_MAX), .TIMEOUT(TMO)) dut (
      .clk(clk), .rst_n(rst_n),
      .usr_data(usr_data), .usr_valid(usr_valid), .usr_ready(usr_ready), .usr_flush(usr_flush),
      .in_data(in_data), .in_last(in_last), .in_valid(in_valid), .in_ready(in_ready),
      .in_flush_now(in_flush_now), .in_flush_time(in_flush_time), .level(level)
   );

   // Free-running clock, 10 time units per cycle.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [7:0] modelQ[$];
   int   pktLen, boundary, rdCount, accCount, idleCnt, lastCount, nowCount;
   logic expNow, prevStall, prevReq, prevLast;
   logic [7:0] prevData;

   task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic modelReset();
      modelQ.delete();
      pktLen = 0; boundary = -1; rdCount = 0; accCount = 0; idleCnt = 0;
      lastCount = 0; nowCount = 0;
      expNow = 1'b0; prevStall = 1'b0; prevReq = 1'b0; prevLast = 1'b0; prevData = 8'h00;
   endtask

   task automatic checkOutput();
      checkVal("level", level, modelQ.size());
      checkVal("usr_ready", usr_ready, modelQ.size() != DEPTH);
      checkVal("flush_now", in_flush_now, expNow);
      checkVal("flush_time", in_flush_time, EXP_FT);
      if (in_flush_now) nowCount++;
   endtask

   // One clock cycle: drive inputs, update the model from observed handshakes, check after the edge.
   task automatic applyStimulus(input logic v, input logic [7:0] d, input logic f, input logic r);
      logic wr, hs, req, expLast, nextNow;
      logic [7:0] expD;
      int idx;
      usr_valid = v; usr_data = d; usr_flush = f; in_ready = r;
      #1;
      wr = usr_valid & usr_ready;
      hs = in_valid & in_ready;
      req = usr_flush;
      nextNow = 1'b0;
      if (prevStall) begin
         checkVal("stall_valid", in_valid, 1);
         checkVal("stall_data", in_data, prevData);
         if (!prevReq) checkVal("stall_last", in_last, prevLast);
      end
      if (in_last) checkVal("last_without_valid", in_valid, 1);
`ifdef MUACM_TX_TIMEOUT_EN
      if (wr) idleCnt = 0;
      else if (modelQ.size() > 0 || pktLen > 0) begin
         idleCnt++;
         if (idleCnt == TMO) begin req = 1'b1; idleCnt = 0; end
      end else idleCnt = 0;
`endif
      if (hs) begin
         idx = rdCount + 1;
         expLast = (pktLen + 1 == PKT_MAX) || (boundary == idx);
         checkVal("read_with_data", modelQ.size() != 0, 1);
         expD = (modelQ.size() != 0) ? modelQ.pop_front() : 8'hxx;
         checkVal("in_data", in_data, expD);
         checkVal("in_last", in_last, expLast);
         if (in_last) lastCount++;
         pktLen = expLast ? 0 : pktLen + 1;
         if (boundary == idx) begin nextNow = 1'b1; boundary = -1; end
         rdCount++;
      end
      if (wr) begin modelQ.push_back(usr_data); accCount++; end
      if (req) begin
         if (modelQ.size() > 0) boundary = accCount;
         else if (pktLen > 0 && !expNow) begin nextNow = 1'b1; pktLen = 0; end
      end
      prevStall = in_valid & ~in_ready;
      prevData  = in_data;
      prevLast  = in_last;
      prevReq   = req;
      @(posedge clk);
      #1;
      expNow = nextNow;
      checkOutput();
   endtask

   task automatic doReset();
      usr_valid = 1'b0; usr_data = 8'h00; usr_flush = 1'b0; in_ready = 1'b0;
      rst_n = 1'b0;
      #1;
      checkVal("rst_in_valid", in_valid, 0);
      checkVal("rst_in_last", in_last, 0);
      checkVal("rst_flush_now", in_flush_now, 0);
      checkVal("rst_level", level, 0);
      checkVal("rst_in_data", in_data, 8'h00);
      checkVal("rst_flush_time", in_flush_time, EXP_FT);
      repeat (2) @(posedge clk);
      #3;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      modelReset();
      checkVal("rst_usr_ready", usr_ready, 1);
      checkOutput();
   endtask

   task automatic drain(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
   endtask

   initial begin
      rst_n = 1'b1;
      modelReset();
      doReset();

      // Three bytes: first in_valid two cycles after the first write.
      applyStimulus(1'b1, 8'h41, 1'b0, 1'b1);
      checkVal("lat_n1_valid", in_valid, 0);
      applyStimulus(1'b1, 8'h42, 1'b0, 1'b1);
      checkVal("lat_n2_valid", in_valid, 1);
      checkVal("lat_n2_data", in_data, 8'h41);
      applyStimulus(1'b1, 8'h43, 1'b0, 1'b1);
      drain(5);
      checkVal("three_read", rdCount, 3);
      checkVal("three_no_last", lastCount, 0);

      // 130-byte stream: in_last on bytes 64 and 128 only.
      doReset();
      for (int i = 0; i < 130; i++) applyStimulus(1'b1, 8'(i), 1'b0, 1'b1);
      drain(5);
      checkVal("stream_read", rdCount, 130);
      checkVal("stream_lasts", lastCount, 2);

      // Five bytes, stalled, then user flush.
      doReset();
      for (int i = 0; i < 5; i++) applyStimulus(1'b1, 8'hA0 + 8'(i), 1'b0, 1'b0);
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      drain(8);
      checkVal("flush_lasts", lastCount, 1);
      checkVal("flush_pulses", nowCount, 1);

      // Fill to full, one read re-opens usr_ready, no write-through on full.
      doReset();
      for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 8'(3 * i), 1'b0, 1'b0);
      applyStimulus(1'b1, 8'hEE, 1'b0, 1'b0);
      checkVal("full_level", level, DEPTH);
      checkVal("full_ready", usr_ready, 0);
      applyStimulus(1'b1, 8'hEE, 1'b0, 1'b1);
      checkVal("after_read_ready", usr_ready, 1);
      checkVal("after_read_level", level, DEPTH - 1);
      drain(80);
      checkVal("full_all_read", rdCount, DEPTH);

      // Two bytes then idle with the pipe stalled: timeout behaviour.
      doReset();
      applyStimulus(1'b1, 8'h31, 1'b0, 1'b0);
      applyStimulus(1'b1, 8'h32, 1'b0, 1'b0);
      for (int i = 0; i < 20; i++) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      drain(10);
      checkVal("idle_read", rdCount, 2);
`ifdef MUACM_TX_TIMEOUT_EN
      checkVal("idle_lasts", lastCount, 1);
      checkVal("idle_pulses", nowCount, 1);
`else
      checkVal("idle_lasts", lastCount, 0);
      checkVal("idle_pulses", nowCount, 0);
`endif

      // Reset in the middle of a flush with ten bytes buffered.
      doReset();
      for (int i = 0; i < 12; i++) applyStimulus(1'b1, 8'h60 + 8'(i), 1'b0, 1'b0);
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
      checkVal("midflush_level", level, 10);
      #2;
      doReset();
      applyStimulus(1'b1, 8'h5A, 1'b0, 1'b1);
      drain(4);
      checkVal("post_reset_read", rdCount, 1);
      checkVal("post_reset_lasts", lastCount, 0);

      // Randomized traffic with stalls and flushes.
      doReset();
      for (int i = 0; i < 3000; i++) begin
         logic v, r, f;
         v = ($urandom_range(0, 99) < 60);
         r = ($urandom_range(0, 99) < 70);
         f = !r && ($urandom_range(0, 15) == 0);
         applyStimulus(v, 8'($urandom), f, r);
      end
      for (int i = 0; i < 200 && modelQ.size() != 0; i++) applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
      checkVal("random_drained", modelQ.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/muacm_tx_packer.md
# muacm_tx_packer

Transmit-side packetiser feeding the IN (device→host) pipe of `muacm`. It accepts a user byte stream with valid/ready, buffers it in an internal FIFO and drives `in_data`/`in_last`/`in_valid`. It closes USB packets at `PKT_MAX` bytes, on explicit user flush, or on idle timeout, and it generates `in_flush_now`/`in_flush_time`. It replaces the loopback wiring in the top level whenever user logic originates the serial data.

## Interface
- `DEPTH`, 64 — FIFO entries; power of two, 4..512.
- `PKT_MAX`, 64 — max bytes per IN packet; 1..64.
- `TIMEOUT`, 1023 — idle cycles before a forced flush; 1..65535; used only with `MUACM_TX_TIMEOUT_EN`.

- `clk`  in  1 — single clock, same domain as `muacm`.
- `rst_n`  in  1 — asynchronous, active-low reset.
- `usr_data`  in  8 — user byte.
- `usr_valid`  in  1 — user byte present.
- `usr_ready`  out  1 — FIFO can accept; equals not full.
- `usr_flush`  in  1 — single-cycle request to close the packet after all bytes buffered so far.
- `in_data`  out  8 — to `muacm` `in_data`.
- `in_last`  out  1 — to `muacm` `in_last`.
- `in_valid`  out  1 — to `muacm` `in_valid`.
- `in_ready`  in  1 — from `muacm` `in_ready`.
- `in_flush_now`  out  1 — to `muacm`; one-cycle pulse.
- `in_flush_time`  out  1 — to `muacm`.
- `level`  out  clog2(DEPTH)+1 — bytes currently buffered.

## Operation
- FIFO
  - Write on `usr_valid & usr_ready`.
  - Read on `in_valid & in_ready`.
  - Head is presented show-ahead through a registered read stage; `in_valid` = head register valid.
  - `level` counts every byte accepted and not yet read. This includes the byte held in the head register.
- Packet counter `pcnt`, 0..PKT_MAX-1
  - Increments on each IN handshake.
  - Returns to 0 on a handshake with `in_last=1`, or on an `in_flush_now` pulse.
- Flush counter `fcnt`, 0..DEPTH
  - A flush request is `usr_flush` or a timeout event.
  - On a flush request, `fcnt` loads the current `level`. The load includes a byte written in the same cycle.
  - Each IN handshake decrements a nonzero `fcnt`.
  - A new request while `fcnt≠0` reloads `fcnt`, which extends the flush.
- `in_last` = `in_valid & (pcnt==PKT_MAX-1 | fcnt==1)`.
- State machine
  - IDLE: `level==0`, `pcnt==0`, `fcnt==0`.
    - Goes to STREAM on a write.
  - STREAM: bytes flowing.
    - Goes to FLUSH on a flush request with `level>0`.
    - A flush request with `level==0` and `pcnt>0` pulses `in_flush_now` next cycle and goes to IDLE.
    - A flush request with `level==0` and `pcnt==0` is a no-op.
  - FLUSH: draining `fcnt` bytes.
    - Goes to STREAM, or to IDLE if the FIFO is empty, on the handshake with `fcnt==1`.
    - That handshake pulses `in_flush_now` on the following cycle.
- Full FIFO: `usr_ready=0`. A read frees one slot, and `usr_ready` rises on the next cycle (no write-through on full).
- Empty FIFO: `in_valid=0`. `in_last` is never asserted without `in_valid`.
- Reset (any time, including mid-packet or mid-flush)
  - FIFO content is discarded; all counters are cleared; state returns to IDLE.
  - Outputs: `usr_ready=1` once `rst_n` is high, `in_valid=0`, `in_last=0`, `in_flush_now=0`, `level=0`, `in_data=8'h00`.
  - `in_flush_time` takes its configuration constant.

## Timing
- Latency: a byte written at cycle N is visible on `in_valid` at N+2 when the FIFO was empty. A back-to-back stream then sustains 1 byte/cycle.
- `level` updates the cycle after the handshake.
- `in_data` and `in_last` are stable while `in_valid=1` and `in_ready=0`.
- `in_flush_now` is a registered, exactly one-cycle pulse.

## Configuration
- `MUACM_TX_TIMEOUT_EN` defined:
  - An idle counter counts cycles with no write while `level>0` or `pcnt>0`.
  - Any write clears it to 0.
  - Reaching `TIMEOUT` raises a single flush request, then the counter clears.
  - `in_flush_time=0`, so `muacm`'s internal timer is disabled.
- `MUACM_TX_TIMEOUT_EN` undefined:
  - No idle counter; flushes come only from `usr_flush`.
  - `in_flush_time=1`, so `muacm`'s own timer handles flushing.

## Test plan
- Reset, then write 3 bytes 0x41,0x42,0x43 with `in_ready=1` → first `in_valid` 2 cycles after the first write; data in order; `in_last=0`; `level` returns to 0.
- Stream 130 bytes, `PKT_MAX=64`, `in_ready=1` → `in_last` on bytes 64 and 128 only.
- Write 5 bytes, hold `in_ready=0`, pulse `usr_flush`, release `in_ready` → `in_last` on the 5th byte; one-cycle `in_flush_now` on the cycle after it; `pcnt` back to 0.
- Fill `DEPTH=64` with `in_ready=0` → `usr_ready=0` at `level=64`; one read raises `usr_ready` the next cycle; no byte lost or duplicated.
- With `MUACM_TX_TIMEOUT_EN`, `TIMEOUT=16`: write 2 bytes, then idle → `in_last` on byte 2 and `in_flush_now` pulse; `in_flush_time=0`. Without the macro: no `in_last`, `in_flush_time=1`.
- Assert `rst_n=0` mid-flush with `level=10` → all outputs at reset values immediately; after release, a new 1-byte stream emerges correctly.
